// File: rtl/oled_cmd_pkg.sv
// SSD1306 command opcodes and decoder state encoding,
// shared by the OLED controller and the SPI sink emulator.
package oled_cmd_pkg;

  localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
  localparam logic [7:0] OP_DISP_ON     = 8'hAF;
  localparam logic [7:0] OP_ENTIRE_OFF  = 8'hA4;
  localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] OP_CHG_PUMP    = 8'h8D;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_COM_PINS    = 8'hDA;
  localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
  localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] OP_VCOMH       = 8'hDB;
  localparam logic [7:0] OP_ADDR_MODE   = 8'h20;

  localparam logic [7:0] CONTRAST_RST   = 8'h7F;

  typedef enum logic [1:0] {
    ST_CMD  = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } dec_state_t;

  // Number of argument bytes that follow an opcode.
  function automatic logic [1:0] arg_count(
    input logic [7:0] op
  );
    logic [1:0] n;
    n = 2'd0;
    case (op)
      OP_CONTRAST,
      OP_CHG_PUMP,
      OP_PRECHARGE,
      OP_COM_PINS,
      OP_CLK_DIV,
      OP_MUX_RATIO,
      OP_DISP_OFFSET,
      OP_VCOMH,
      OP_ADDR_MODE: n = 2'd1;
      OP_COL_ADDR,
      OP_PAGE_ADDR: n = 2'd2;
      default:      n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/oled_spi_sink_if.sv
// OLED SPI link pins: chip select, clock, data, data/command.
// The controller drives them; the sink only listens.
interface oled_spi_sink_if;

  logic CS;
  logic SCLK;
  logic SDIN;
  logic DC;

  modport master (
    output CS,
    output SCLK,
    output SDIN,
    output DC
  );

  modport slave (
    input CS,
    input SCLK,
    input SDIN,
    input DC
  );

endinterface

// File: rtl/oled_spi_sink_rx.sv
// SPI byte receiver: synchronizers, SCLK edge detect,
// MSB-first shifter, bit count and framing error.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  oled_spi_sink_if.slave   spi,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_dc,
  output logic             frame_err
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sdin_sync;
  logic [SYNC_STAGES-1:0] dc_sync;

  logic sclk_s;
  logic cs_s;
  logic sdin_s;
  logic dc_s;

  logic       sclk_d;
  logic       rise_q;
  logic       sdin_q;
  logic       dc_q;
  logic [2:0] cnt;
  logic [6:0] sr;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sdin_s = sdin_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  // Synchronizers reset to the idle bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      sdin_sync <= '0;
      dc_sync   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], spi.SDIN};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi.DC};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d     <= 1'b1;
      rise_q     <= 1'b0;
      sdin_q     <= 1'b0;
      dc_q       <= 1'b0;
      cnt        <= 3'd0;
      sr         <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_dc    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      sclk_d     <= sclk_s;
      rise_q     <= sclk_s & ~sclk_d & ~cs_s;
      sdin_q     <= sdin_s;
      dc_q       <= dc_s;
      if (cs_s) begin
        cnt       <= 3'd0;
        frame_err <= (cnt != 3'd0);
      end else if (rise_q) begin
        sr <= {sr[5:0], sdin_q};
        if (cnt == 3'd7) begin
          cnt        <= 3'd0;
          byte_valid <= 1'b1;
          byte_data  <= {sr, sdin_q};
          byte_dc    <= dc_q;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_sink.sv
// SSD1306-style display emulator: decodes command bytes and
// turns data bytes into frame-buffer writes.
module oled_spi_sink
  import oled_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 4
) (
  input  logic           clk,
  input  logic           rst,
  oled_spi_sink_if.slave spi,
  output logic           byte_valid,
  output logic [7:0]     byte_data,
  output logic           byte_dc,
  output logic           fb_we,
  output logic [8:0]     fb_addr,
  output logic [7:0]     fb_data,
  output logic           disp_on,
  output logic           disp_full,
  output logic [7:0]     contrast,
  output logic           frame_err
);

  dec_state_t state;
  logic [7:0] op_q;
  logic       two_args;
  logic [1:0] page;
  logic [6:0] col;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .frame_err  (frame_err)
  );

  assign fb_we   = byte_valid & byte_dc;
  assign fb_addr = {page, col};
  assign fb_data = byte_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CMD;
      op_q      <= 8'd0;
      two_args  <= 1'b0;
      page      <= 2'd0;
      col       <= 7'd0;
      disp_on   <= 1'b0;
      disp_full <= 1'b0;
      contrast  <= CONTRAST_RST;
    end else if (byte_valid) begin
      if (byte_dc) begin
        // Data aborts any pending argument sequence.
        state <= ST_CMD;
        if (col == 7'(COLS - 1)) begin
          col <= 7'd0;
          if (page == 2'(PAGES - 1))
            page <= 2'd0;
          else
            page <= page + 2'd1;
        end else begin
          col <= col + 7'd1;
        end
      end else begin
        unique case (state)
          ST_CMD: begin
            unique case (1'b1)
              (byte_data[7:1] == OP_DISP_OFF[7:1]):
                disp_on <= byte_data[0];
              (byte_data[7:1] == OP_ENTIRE_OFF[7:1]):
                disp_full <= byte_data[0];
              (byte_data[7:2] == 6'b1011_00):
                page <= byte_data[1:0];
              (byte_data[7:4] == 4'h0):
                col[3:0] <= byte_data[3:0];
              (byte_data[7:3] == 5'b0001_0):
                col[6:4] <= byte_data[2:0];
              (arg_count(byte_data) != 2'd0): begin
                op_q     <= byte_data;
                two_args <= (arg_count(byte_data) == 2'd2);
                state    <= ST_ARG1;
              end
              default: ;
            endcase
          end
          ST_ARG1: begin
            case (op_q)
              OP_CONTRAST:  contrast <= byte_data;
              OP_PAGE_ADDR: page     <= byte_data[1:0];
              OP_COL_ADDR:  col      <= byte_data[6:0];
              default: ;
            endcase
            state <= two_args ? ST_ARG2 : ST_CMD;
          end
          ST_ARG2: state <= ST_CMD;
          default: state <= ST_CMD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Scoreboard bench for oled_spi_sink: directed SPI traffic,
// expected bytes queued by stimulus and checked by a monitor.
module tb_oled_spi_sink;
  import oled_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       fb_we;
  logic [8:0] fb_addr;
  logic [7:0] fb_data;
  logic       disp_on;
  logic       disp_full;
  logic [7:0] contrast;
  logic       frame_err;

  always #5 clk = ~clk;

  oled_spi_sink_if spi();

  oled_spi_sink #(
    .SYNC_STAGES (2),
    .COLS        (128),
    .PAGES       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .disp_on    (disp_on),
    .disp_full  (disp_full),
    .contrast   (contrast),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [8:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   fe_seen  = 0;
  int   fe_exp   = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (frame_err) fe_seen++;
    if (byte_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte got=%h dc=%b exp=none",
                 byte_data, byte_dc);
      end else begin
        e = q.pop_front();
        if (e.dc)
          ok = fb_we && byte_dc && byte_data == e.data &&
               fb_data == e.data && fb_addr == e.addr;
        else
          ok = !fb_we && !byte_dc && byte_data == e.data;
        if (!ok) begin
          failures++;
          $display("FAIL byte got=%h/%b we=%b addr=%h exp=%h/%b addr=%h",
                   byte_data, byte_dc, fb_we, fb_addr,
                   e.data, e.dc, e.addr);
        end
      end
    end else if (fb_we) begin
      checks++;
      failures++;
      $display("FAIL stray_fb_we got=1 exp=0");
    end
  end

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b,
                           input int n,
                           input logic dc);
    if (spi.CS) begin
      spi.CS = 1'b0;
      repeat (4) @(negedge clk);
    end
    spi.DC = dc;
    for (int i = 7; i > 7 - n; i--) begin
      spi.SCLK = 1'b0;
      spi.SDIN = b[i];
      repeat (4) @(negedge clk);
      spi.SCLK = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    q.push_back('{data: b, dc: 1'b0, addr: 9'd0});
    send_bits(b, 8, 1'b0);
  endtask

  task automatic data(input logic [7:0] b,
                      input logic [8:0] a);
    q.push_back('{data: b, dc: 1'b1, addr: a});
    send_bits(b, 8, 1'b1);
  endtask

  task automatic cs_high();
    spi.CS = 1'b1;
    settle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    spi.CS   = 1'b1;
    spi.SCLK = 1'b1;
    spi.SDIN = 1'b0;
    spi.DC   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_contrast", 32'(contrast), 32'h7F);
    check("rst_disp_on", 32'(disp_on), 0);
    check("rst_disp_full", 32'(disp_full), 0);
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_frame_err", 32'(frame_err), 0);

    cmd(8'hAF);
    cmd(8'hA5);
    settle();
    check("full_set", 32'(disp_full), 1);
    cmd(8'hA4);
    settle();
    check("full_clr", 32'(disp_full), 0);
    check("disp_on_set", 32'(disp_on), 1);

    cmd(8'h81);
    cmd(8'h0F);
    settle();
    check("contrast_0f", 32'(contrast), 32'h0F);
    cmd(8'hAE);
    settle();
    check("disp_on_clr", 32'(disp_on), 0);

    cmd(8'h22);
    cmd(8'h02);
    cmd(8'h00);
    cmd(8'h10);
    for (int i = 0; i < 128; i++)
      data(8'(i), 9'h100 + 9'(i));
    data(8'hAA, 9'h180);
    cs_high();
    do_reset();
    check("rst2_contrast", 32'(contrast), 32'h7F);

    for (int i = 0; i < 512; i++)
      data(8'(i ^ 8'h3C), 9'(i));
    data(8'hEE, 9'h000);
    cs_high();

    send_bits(8'hA5, 5, 1'b0);
    repeat (2) @(negedge clk);
    cs_high();
    fe_exp++;
    check("frame_err_cnt", 32'(fe_seen), 32'(fe_exp));
    check("partial_full", 32'(disp_full), 0);
    cmd(8'hA5);
    settle();
    check("full_after_err", 32'(disp_full), 1);
    cs_high();

    send_bits(8'hC3, 4, 1'b1);
    repeat (2) @(negedge clk);
    do_reset();
    cs_high();
    check("rst_mid_fe", 32'(fe_seen), 32'(fe_exp));
    check("rst_mid_full", 32'(disp_full), 0);
    data(8'h5A, 9'h000);

    cmd(8'h81);
    data(8'h33, 9'h001);
    cmd(8'hA5);
    settle();
    check("abort_contrast", 32'(contrast), 32'h7F);
    check("abort_full", 32'(disp_full), 1);
    cs_high();

    check("queue_empty", 32'(q.size()), 0);
    check("frame_err_total", 32'(fe_seen), 32'(fe_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
